// File: rtl/unidade_controle.sv
// unidade_controle: multicycle control unit for the single-datapath processor.
// Sequences fetch / decode / execute / memory / write-back for LD, SD, ADD,
// SUB, ADDI and SUBI, owns run/halt control and the retired-instruction count.
// All outputs are registered: each is computed from the state being entered,
// so it is high for exactly the cycles spent in that state.
module unidade_controle #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [31:0]      ir_in,
    output logic             pc_we,
    output logic             ir_we,
    output logic             rf_we,
    output logic             mem_we,
    output logic             alu_sub,
    output logic             sel_b,
    output logic             sel_wb,
    output logic             busy,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD_IR,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_MEM_WAIT,
        S_WB,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_LD,
        C_SD,
        C_ADD,
        C_SUB,
        C_ADDI,
        C_SUBI,
        C_HALT,
        C_ILL
    } iclass_t;

    typedef struct packed {
        logic pc_we;
        logic ir_we;
        logic rf_we;
        logic mem_we;
        logic alu_sub;
        logic sel_b;
        logic sel_wb;
        logic busy;
        logic halted;
    } ctrl_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_ADDI  = 7'b0010011;
    localparam logic [6:0] OP_SUBI  = 7'b0001011;
    localparam logic [2:0] F3_DW    = 3'b011;
    localparam logic [2:0] F3_ARITH = 3'b000;
    localparam logic [6:0] F7_ADD   = 7'b0000000;
    localparam logic [6:0] F7_SUB   = 7'b0100000;

    state_t           r_state;
    ctrl_t            r_ctrl;
    logic             r_illegal;
    logic             r_stop;
    logic [CNT_W-1:0] r_count;

    state_t           w_state_nxt;
    iclass_t          w_cls;
    logic             w_retire;
    logic             w_stop_any;
    logic [6:0]       w_opcode;
    logic [2:0]       w_funct3;
    logic [6:0]       w_funct7;

    assign w_opcode = ir_in[6:0];
    assign w_funct3 = ir_in[14:12];
    assign w_funct7 = ir_in[31:25];

    // Classify the word currently held in IR.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can leave it unassigned and infer a latch.
        w_cls = C_ILL;
        if (ir_in == 32'h0000_0000) begin
            w_cls = C_HALT;
        end else begin
            unique case (w_opcode)
                OP_LOAD:  if (w_funct3 == F3_DW)    w_cls = C_LD;
                OP_STORE: if (w_funct3 == F3_DW)    w_cls = C_SD;
                OP_ADDI:  if (w_funct3 == F3_ARITH) w_cls = C_ADDI;
                OP_SUBI:  if (w_funct3 == F3_ARITH) w_cls = C_SUBI;
                OP_REG: begin
                    if (w_funct3 == F3_ARITH && w_funct7 == F7_ADD) w_cls = C_ADD;
                    if (w_funct3 == F3_ARITH && w_funct7 == F7_SUB) w_cls = C_SUB;
                end
                default: w_cls = C_ILL;
            endcase
        end
    end

    // An instruction retires on the edge leaving SD's MEM cycle or any WB cycle.
    assign w_retire   = (r_state == S_WB) || (r_state == S_MEM && w_cls == C_SD);
    // A stop arriving in the retire cycle itself counts as already latched.
    assign w_stop_any = r_stop | stop;

    // Next-state selection.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:     if (start) w_state_nxt = S_FETCH;
            S_FETCH:    w_state_nxt = S_LOAD_IR;
            S_LOAD_IR:  w_state_nxt = S_DECODE;
            S_DECODE:   w_state_nxt = (w_cls == C_HALT || w_cls == C_ILL) ? S_HALT : S_EXEC;
            S_EXEC:     w_state_nxt = (w_cls == C_LD || w_cls == C_SD) ? S_MEM : S_WB;
            S_MEM: begin
                if (w_cls == C_SD) w_state_nxt = w_stop_any ? S_IDLE : S_FETCH;
                else               w_state_nxt = S_MEM_WAIT;
            end
            S_MEM_WAIT: w_state_nxt = S_WB;
            S_WB:       w_state_nxt = w_stop_any ? S_IDLE : S_FETCH;
            S_HALT:     if (start) w_state_nxt = S_FETCH;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // Control word that belongs to state s for an instruction of class c.
    function automatic ctrl_t f_ctrl(input state_t s, input iclass_t c);
        ctrl_t o;
        logic  is_sub;
        logic  reg_b;
        o      = '0;
        is_sub = (c == C_SUB) || (c == C_SUBI);
        reg_b  = (c == C_ADD) || (c == C_SUB);
        unique case (s)
            S_FETCH, S_DECODE: o.busy = 1'b1;
            S_LOAD_IR: begin
                o.busy  = 1'b1;
                o.ir_we = 1'b1;
                o.pc_we = 1'b1;
            end
            S_EXEC, S_MEM_WAIT: begin
                o.busy    = 1'b1;
                o.alu_sub = is_sub;
                o.sel_b   = reg_b;
            end
            S_MEM: begin
                o.busy    = 1'b1;
                o.alu_sub = is_sub;
                o.sel_b   = reg_b;
                o.mem_we  = (c == C_SD);
            end
            S_WB: begin
                o.busy   = 1'b1;
                o.rf_we  = 1'b1;
                o.sel_wb = (c != C_LD);
            end
            S_HALT:  o.halted = 1'b1;
            default: o = '0;
        endcase
        return o;
    endfunction

    // State, registered control outputs, sticky illegal flag, stop latch and retire counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state   <= S_IDLE;
            r_ctrl    <= '0;
            r_illegal <= 1'b0;
            r_stop    <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ctrl  <= f_ctrl(w_state_nxt, w_cls);

            if ((r_state == S_IDLE || r_state == S_HALT) && start)
                r_illegal <= 1'b0;
            else if (r_state == S_DECODE && w_cls == C_ILL)
                r_illegal <= 1'b1;

            // Stop is only meaningful while running; it clears once honoured.
            if (r_state == S_IDLE || r_state == S_HALT || w_retire)
                r_stop <= 1'b0;
            else if (stop)
                r_stop <= 1'b1;

            if (w_retire)
                r_count <= r_count + 1'b1;
        end
    end

    assign pc_we       = r_ctrl.pc_we;
    assign ir_we       = r_ctrl.ir_we;
    assign rf_we       = r_ctrl.rf_we;
    assign mem_we      = r_ctrl.mem_we;
    assign alu_sub     = r_ctrl.alu_sub;
    assign sel_b       = r_ctrl.sel_b;
    assign sel_wb      = r_ctrl.sel_wb;
    assign busy        = r_ctrl.busy;
    assign halted      = r_ctrl.halted;
    assign illegal     = r_illegal;
    assign instr_count = r_count;

endmodule

// File: tb/tb_unidade_controle.sv
// tb_unidade_controle: directed bench for the control unit. A tiny PC/IR/
// instruction-memory model feeds ir_in; every cycle's control word is compared
// against hand-written constants.
module tb_unidade_controle;

    localparam int CNT_W = 4;

    // Control word packing: {pc_we, ir_we, rf_we, mem_we, alu_sub, sel_b, sel_wb, busy, halted}
    localparam logic [8:0] V_IDLE   = 9'b000000000;
    localparam logic [8:0] V_FETCH  = 9'b000000010;
    localparam logic [8:0] V_LOADIR = 9'b110000010;
    localparam logic [8:0] V_DECODE = 9'b000000010;
    localparam logic [8:0] V_EX_ADD = 9'b000001010;
    localparam logic [8:0] V_EX_SUB = 9'b000011010;
    localparam logic [8:0] V_EX_ADI = 9'b000000010;
    localparam logic [8:0] V_EX_SBI = 9'b000010010;
    localparam logic [8:0] V_EX_MEM = 9'b000000010;
    localparam logic [8:0] V_MEM_SD = 9'b000100010;
    localparam logic [8:0] V_MEM_LD = 9'b000000010;
    localparam logic [8:0] V_WB_AR  = 9'b001000110;
    localparam logic [8:0] V_WB_LD  = 9'b001000010;
    localparam logic [8:0] V_HALT   = 9'b000000001;

    localparam logic [31:0] I_ADD  = 32'h0020_81B3;
    localparam logic [31:0] I_SUB  = 32'h4020_81B3;
    localparam logic [31:0] I_ADDI = 32'h0050_8193;
    localparam logic [31:0] I_SUBI = 32'h0050_818B;
    localparam logic [31:0] I_LD   = 32'h0000_B183;
    localparam logic [31:0] I_SD   = 32'h0020_B023;
    localparam logic [31:0] I_HALT = 32'h0000_0000;
    localparam logic [31:0] I_BAD  = 32'h0000_007F;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             stop;
    logic [31:0]      ir_in;
    logic             pc_we, ir_we, rf_we, mem_we, alu_sub, sel_b, sel_wb, busy, halted, illegal;
    logic [CNT_W-1:0] instr_count;
    logic [8:0]       w_outs;

    logic [31:0]      imem [0:31];
    logic [4:0]       pc;
    logic [31:0]      ir;

    int n_tests = 0;
    int n_fail  = 0;

    unidade_controle #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .ir_in(ir_in),
        .pc_we(pc_we), .ir_we(ir_we), .rf_we(rf_we), .mem_we(mem_we),
        .alu_sub(alu_sub), .sel_b(sel_b), .sel_wb(sel_wb), .busy(busy),
        .halted(halted), .illegal(illegal), .instr_count(instr_count)
    );

    assign w_outs = {pc_we, ir_we, rf_we, mem_we, alu_sub, sel_b, sel_wb, busy, halted};
    assign ir_in  = ir;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC and IR registers of the datapath, loaded by the DUT's enables.
    always @(posedge clk) begin
        if (!rst_n) begin
            pc <= '0;
            ir <= '0;
        end else begin
            if (ir_we) ir <= imem[pc];
            if (pc_we) pc <= pc + 5'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one cycle and compare the control word.
    task automatic cyc(input string tag, input logic [8:0] exp);
        @(negedge clk);
        check(tag, 32'(w_outs), 32'(exp));
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) imem[i] = I_HALT;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [31:0] t3_ins  [3];
    logic [8:0]  t3_exec [3];

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        t3_ins[0] = I_SUBI; t3_exec[0] = V_EX_SBI;
        t3_ins[1] = I_SUB;  t3_exec[1] = V_EX_SUB;
        t3_ins[2] = I_ADDI; t3_exec[2] = V_EX_ADI;

        // ADD trace from reset
        clear_mem();
        imem[0] = I_ADD;
        do_reset();
        check("rst_outs", 32'(w_outs), 32'(V_IDLE));
        check("rst_cnt", 32'(instr_count), 32'd0);
        check("rst_ill", 32'(illegal), 32'd0);
        start = 1'b1;
        cyc("add_fetch", V_FETCH);
        start = 1'b0;
        cyc("add_loadir", V_LOADIR);
        cyc("add_decode", V_DECODE);
        cyc("add_exec", V_EX_ADD);
        cyc("add_wb", V_WB_AR);
        check("add_cnt_wb", 32'(instr_count), 32'd0);
        cyc("add_fetch2", V_FETCH);
        check("add_cnt", 32'(instr_count), 32'd1);
        cyc("add_loadir2", V_LOADIR);
        cyc("add_decode2", V_DECODE);
        cyc("add_halt", V_HALT);
        check("add_halt_ill", 32'(illegal), 32'd0);

        // LD then SD back to back
        clear_mem();
        imem[0] = I_LD;
        imem[1] = I_SD;
        do_reset();
        start = 1'b1;
        cyc("ld_fetch", V_FETCH);
        start = 1'b0;
        cyc("ld_loadir", V_LOADIR);
        cyc("ld_decode", V_DECODE);
        cyc("ld_exec", V_EX_MEM);
        cyc("ld_mem", V_MEM_LD);
        cyc("ld_memwait", V_MEM_LD);
        cyc("ld_wb", V_WB_LD);
        cyc("sd_fetch", V_FETCH);
        check("ld_cnt", 32'(instr_count), 32'd1);
        cyc("sd_loadir", V_LOADIR);
        cyc("sd_decode", V_DECODE);
        cyc("sd_exec", V_EX_MEM);
        cyc("sd_mem", V_MEM_SD);
        cyc("ldsd_fetch", V_FETCH);
        check("ldsd_cnt", 32'(instr_count), 32'd2);
        cyc("ldsd_loadir", V_LOADIR);
        cyc("ldsd_decode", V_DECODE);
        cyc("ldsd_halt", V_HALT);

        // SUBI, SUB, ADDI: operand select and subtract per class
        clear_mem();
        for (int i = 0; i < 3; i++) imem[i] = t3_ins[i];
        do_reset();
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc($sformatf("ar%0d_fetch", i), V_FETCH);
            start = 1'b0;
            check($sformatf("ar%0d_cnt", i), 32'(instr_count), 32'(i));
            cyc($sformatf("ar%0d_loadir", i), V_LOADIR);
            cyc($sformatf("ar%0d_decode", i), V_DECODE);
            cyc($sformatf("ar%0d_exec", i), t3_exec[i]);
            cyc($sformatf("ar%0d_wb", i), V_WB_AR);
        end
        cyc("ar_fetch_end", V_FETCH);
        check("ar_cnt_end", 32'(instr_count), 32'd3);

        // Illegal word halts, start resumes at the next word
        clear_mem();
        imem[0] = I_BAD;
        imem[1] = I_ADD;
        do_reset();
        start = 1'b1;
        cyc("ill_fetch", V_FETCH);
        start = 1'b0;
        cyc("ill_loadir", V_LOADIR);
        cyc("ill_decode", V_DECODE);
        cyc("ill_halt", V_HALT);
        check("ill_flag", 32'(illegal), 32'd1);
        cyc("ill_halt_hold", V_HALT);
        check("ill_cnt", 32'(instr_count), 32'd0);
        start = 1'b1;
        cyc("ill_resume", V_FETCH);
        start = 1'b0;
        check("ill_cleared", 32'(illegal), 32'd0);
        cyc("ill_loadir2", V_LOADIR);
        cyc("ill_decode2", V_DECODE);
        cyc("ill_next_exec", V_EX_ADD);
        cyc("ill_next_wb", V_WB_AR);
        cyc("ill_fetch3", V_FETCH);
        check("ill_cnt2", 32'(instr_count), 32'd1);

        // stop during EXEC, stop in IDLE, stop coinciding with retire
        clear_mem();
        imem[0] = I_ADD;
        imem[1] = I_ADD;
        do_reset();
        start = 1'b1;
        cyc("stp_fetch", V_FETCH);
        start = 1'b0;
        cyc("stp_loadir", V_LOADIR);
        cyc("stp_decode", V_DECODE);
        cyc("stp_exec", V_EX_ADD);
        stop = 1'b1;
        cyc("stp_wb", V_WB_AR);
        stop = 1'b0;
        cyc("stp_idle", V_IDLE);
        check("stp_cnt", 32'(instr_count), 32'd1);
        stop = 1'b1;
        cyc("stp_idle_stop", V_IDLE);
        stop = 1'b0;
        cyc("stp_idle_hold", V_IDLE);
        start = 1'b1;
        cyc("stp2_fetch", V_FETCH);
        start = 1'b0;
        cyc("stp2_loadir", V_LOADIR);
        cyc("stp2_decode", V_DECODE);
        cyc("stp2_exec", V_EX_ADD);
        cyc("stp2_wb", V_WB_AR);
        stop = 1'b1;
        cyc("stp2_idle", V_IDLE);
        stop = 1'b0;
        check("stp2_cnt", 32'(instr_count), 32'd2);

        // Reset during SD's memory cycle
        clear_mem();
        imem[0] = I_SD;
        do_reset();
        start = 1'b1;
        cyc("rsd_fetch", V_FETCH);
        start = 1'b0;
        cyc("rsd_loadir", V_LOADIR);
        cyc("rsd_decode", V_DECODE);
        cyc("rsd_exec", V_EX_MEM);
        cyc("rsd_mem", V_MEM_SD);
        rst_n = 1'b0;
        cyc("rsd_after", V_IDLE);
        check("rsd_mem_we", 32'(mem_we), 32'd0);
        check("rsd_cnt", 32'(instr_count), 32'd0);
        rst_n = 1'b1;
        cyc("rsd_idle", V_IDLE);

        // 16 retires wrap a 4-bit counter
        clear_mem();
        for (int i = 0; i < 16; i++) imem[i] = I_ADD;
        do_reset();
        start = 1'b1;
        cyc("wrap_fetch", V_FETCH);
        start = 1'b0;
        for (int i = 0; i < 200 && !halted; i++) begin
            @(negedge clk);
            if (instr_count == 4'd15 && rf_we)
                check("wrap_cnt15", 32'(pc), 32'd16);
        end
        check("wrap_halted", 32'(halted), 32'd1);
        check("wrap_cnt", 32'(instr_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
